// File: rtl/svx32_rvfi_event_monitor.sv
// svx32_rvfi_event_monitor
//   RVFI event monitor for the sparrowx32 core. Counts retired dmem reads,
//   dmem writes, 32-bit insns, compressed insns and traps over NRET
//   retirement channels, and raises pol_goal_met once every counter has
//   reached its programmable threshold.
//
//   Counter / threshold packing (both buses): {trap, compr, long, wr, rd},
//   rd in [CNT_W-1:0].
//
//   Optional feature macro: SVX32_EVT_ORDER_CHECK_EN
//     defined   : retire-order contiguity checker drives pol_order_err
//     undefined : piv_rvfi_order ignored, pol_order_err tied low
//
//   Handshake: piv_rvfi_valid[i] is a single-cycle retire strobe with no
//   ready/backpressure; every retirement presented on a posedge while the
//   FSM is in RUN (and no arm/clr is present) is counted exactly once.
//   The FSM state is exported on pov_state for checkers.
module svx32_rvfi_event_monitor #(
  parameter int NRET  = 1,
  parameter int CNT_W = 16
) (
  input  logic                  pil_clk,
  input  logic                  pil_rst_n,
  input  logic                  pil_arm,
  input  logic                  pil_clr,
  input  logic [NRET-1:0]       piv_rvfi_valid,
  input  logic [32*NRET-1:0]    piv_rvfi_insn,
  input  logic [NRET-1:0]       piv_rvfi_trap,
  input  logic [4*NRET-1:0]     piv_rvfi_mem_rmask,
  input  logic [4*NRET-1:0]     piv_rvfi_mem_wmask,
  input  logic [64*NRET-1:0]    piv_rvfi_order,
  input  logic [5*CNT_W-1:0]    piv_thresh,
  output logic [5*CNT_W-1:0]    pov_cnt,
  output logic [1:0]            pov_state,
  output logic                  pol_goal_met,
  output logic                  pol_sat,
  output logic                  pol_order_err
);

  localparam int INC_W = $clog2(NRET + 1);
  localparam int SUM_W = CNT_W + 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int EV_RD    = 0;
  localparam int EV_WR    = 1;
  localparam int EV_LONG  = 2;
  localparam int EV_COMPR = 3;
  localparam int EV_TRAP  = 4;

  localparam logic [SUM_W-1:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [1:0]                  state_q, state_d;
  logic [4:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [4:0][CNT_W-1:0]       thr;
  logic [4:0][INC_W-1:0]       inc;
  logic [4:0][SUM_W-1:0]       sum;
  logic                        sat_q, sat_d;
  logic                        goal_hit;
  logic                        restart;

  // Only insn[1:0] of each channel decides long vs compressed.
  logic unused_insn_hi;
  assign unused_insn_hi = |(piv_rvfi_insn & ~{NRET{32'h0000_0003}});

  assign thr     = piv_thresh;
  assign restart = pil_clr | pil_arm;

  // Classify each retirement and popcount the per-class hits over channels.
  always_comb begin
    inc = '0;
    for (int i = 0; i < NRET; i++) begin
      if (piv_rvfi_valid[i]) begin
        if (piv_rvfi_trap[i]) begin
          inc[EV_TRAP] = inc[EV_TRAP] + INC_W'(1);
        end else begin
          if (piv_rvfi_mem_rmask[4*i +: 4] != 4'h0) inc[EV_RD] = inc[EV_RD] + INC_W'(1);
          if (piv_rvfi_mem_wmask[4*i +: 4] != 4'h0) inc[EV_WR] = inc[EV_WR] + INC_W'(1);
          if (piv_rvfi_insn[32*i +: 2] == 2'b11) inc[EV_LONG] = inc[EV_LONG] + INC_W'(1);
          else                                   inc[EV_COMPR] = inc[EV_COMPR] + INC_W'(1);
        end
      end
    end
  end

  // Goal compare on the registered counters, plus one-bit-wider sums for clamping.
  always_comb begin
    goal_hit = 1'b1;
    for (int e = 0; e < 5; e++) begin
      if (cnt_q[e] < thr[e]) goal_hit = 1'b0;
      sum[e] = {1'b0, cnt_q[e]} + SUM_W'(inc[e]);
    end
  end

  // Next-state: arm/clr restart (clr wins), RUN counts with saturation, DONE freezes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (pil_clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (pil_arm) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          for (int e = 0; e < 5; e++) begin
            if (sum[e] > CNT_MAX) begin
              cnt_d[e] = {CNT_W{1'b1}};
              sat_d    = 1'b1;
            end else begin
              cnt_d[e] = sum[e][CNT_W-1:0];
            end
          end
          if (goal_hit) state_d = ST_DONE;
        end
        ST_IDLE, ST_DONE: state_d = state_q;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  // Main state registers.
  always_ff @(posedge pil_clk or negedge pil_rst_n) begin
    if (!pil_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

`ifdef SVX32_EVT_ORDER_CHECK_EN
  logic [63:0] exp_q, exp_d;
  logic        have_q, have_d;
  logic        oerr_q;
  logic        order_viol;

  // Contiguity and order-continuity check across channels; the expectation
  // re-syncs to each observed order so one gap flags once.
  always_comb begin
    exp_d      = exp_q;
    have_d     = have_q;
    order_viol = 1'b0;
    for (int i = 1; i < NRET; i++) begin
      if (piv_rvfi_valid[i] && !piv_rvfi_valid[i-1]) order_viol = 1'b1;
    end
    for (int i = 0; i < NRET; i++) begin
      if (piv_rvfi_valid[i]) begin
        if (have_d && (piv_rvfi_order[64*i +: 64] != exp_d)) order_viol = 1'b1;
        have_d = 1'b1;
        exp_d  = piv_rvfi_order[64*i +: 64] + 64'd1;
      end
    end
  end

  // Order tracking registers; only RUN cycles without a restart update them.
  always_ff @(posedge pil_clk or negedge pil_rst_n) begin
    if (!pil_rst_n) begin
      exp_q  <= '0;
      have_q <= 1'b0;
      oerr_q <= 1'b0;
    end else if (restart) begin
      exp_q  <= '0;
      have_q <= 1'b0;
      oerr_q <= 1'b0;
    end else if (state_q == ST_RUN) begin
      exp_q  <= exp_d;
      have_q <= have_d;
      if (order_viol) oerr_q <= 1'b1;
    end
  end

  assign pol_order_err = oerr_q;
`else
  logic unused_order;
  assign unused_order  = ^{piv_rvfi_order, restart};
  assign pol_order_err = 1'b0;
`endif

  assign pov_cnt      = cnt_q;
  assign pov_state    = state_q;
  assign pol_goal_met = (state_q == ST_DONE);
  assign pol_sat      = sat_q;

endmodule

// File: tb/tb_svx32_rvfi_event_monitor.sv
// tb_svx32_rvfi_event_monitor
//   Three monitors share one stimulus stream:
//     u0: NRET=1 CNT_W=16 (channel 0 only)
//     u1: NRET=2 CNT_W=16
//     u2: NRET=2 CNT_W=4  (own thresholds)
//   A behavioural event model predicts every output each cycle; directed
//   scenarios add hand-computed literal expectations.
module tb_svx32_rvfi_event_monitor;

  localparam int NI     = 3;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
`ifdef SVX32_EVT_ORDER_CHECK_EN
  localparam logic EXP_OERR = 1'b1;
`else
  localparam logic EXP_OERR = 1'b0;
`endif

  localparam logic [31:0] I_LW    = 32'h0001_2083;
  localparam logic [31:0] I_SW    = 32'h0011_2023;
  localparam logic [31:0] I_ADD   = 32'h0031_00B3;
  localparam logic [31:0] I_CADDI = 32'h0000_0085;
  localparam logic [31:0] I_ECALL = 32'h0000_0073;

  // ---------------- clock / reset / stimulus signals ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         arm = 1'b0;
  logic         clr = 1'b0;
  logic [1:0]   valid = '0;
  logic [1:0]   trap = '0;
  logic [63:0]  insn = '0;
  logic [7:0]   rmask = '0;
  logic [7:0]   wmask = '0;
  logic [127:0] order = '0;
  logic [79:0]  thr16 = '0;
  logic [19:0]  thr4 = '0;

  logic [79:0]  cnt0, cnt1;
  logic [19:0]  cnt2;
  logic [1:0]   st0, st1, st2;
  logic         goal0, goal1, goal2;
  logic         sat0, sat1, sat2;
  logic         oerr0, oerr1, oerr2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  svx32_rvfi_event_monitor #(.NRET(1), .CNT_W(16)) u0 (
    .pil_clk(clk), .pil_rst_n(rst_n), .pil_arm(arm), .pil_clr(clr),
    .piv_rvfi_valid(valid[0:0]), .piv_rvfi_insn(insn[31:0]), .piv_rvfi_trap(trap[0:0]),
    .piv_rvfi_mem_rmask(rmask[3:0]), .piv_rvfi_mem_wmask(wmask[3:0]),
    .piv_rvfi_order(order[63:0]), .piv_thresh(thr16),
    .pov_cnt(cnt0), .pov_state(st0), .pol_goal_met(goal0), .pol_sat(sat0),
    .pol_order_err(oerr0)
  );

  svx32_rvfi_event_monitor #(.NRET(2), .CNT_W(16)) u1 (
    .pil_clk(clk), .pil_rst_n(rst_n), .pil_arm(arm), .pil_clr(clr),
    .piv_rvfi_valid(valid), .piv_rvfi_insn(insn), .piv_rvfi_trap(trap),
    .piv_rvfi_mem_rmask(rmask), .piv_rvfi_mem_wmask(wmask),
    .piv_rvfi_order(order), .piv_thresh(thr16),
    .pov_cnt(cnt1), .pov_state(st1), .pol_goal_met(goal1), .pol_sat(sat1),
    .pol_order_err(oerr1)
  );

  svx32_rvfi_event_monitor #(.NRET(2), .CNT_W(4)) u2 (
    .pil_clk(clk), .pil_rst_n(rst_n), .pil_arm(arm), .pil_clr(clr),
    .piv_rvfi_valid(valid), .piv_rvfi_insn(insn), .piv_rvfi_trap(trap),
    .piv_rvfi_mem_rmask(rmask), .piv_rvfi_mem_wmask(wmask),
    .piv_rvfi_order(order), .piv_thresh(thr4),
    .pov_cnt(cnt2), .pov_state(st2), .pol_goal_met(goal2), .pol_sat(sat2),
    .pol_order_err(oerr2)
  );

  // ---------------- behavioural model ----------------
  // Counts are plain integers indexed rd,wr,long,compr,trap.
  longint      m_cnt [NI][5];
  int          m_mode[NI];
  bit          m_sat [NI];
  bit          m_oerr[NI];
  bit          m_have[NI];
  logic [63:0] m_exp [NI];
  string       cls_name[5] = '{"cnt_rd", "cnt_wr", "cnt_long", "cnt_compr", "cnt_trap"};

  function automatic int nret_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int cw_of(input int k);
    return (k == 2) ? 4 : 16;
  endfunction

  function automatic longint thr_of(input int k, input int c);
    if (k < 2) return longint'(thr16[c*16 +: 16]);
    return longint'(thr4[c*4 +: 4]);
  endfunction

  task automatic model_clear(input int k);
    for (int c = 0; c < 5; c++) m_cnt[k][c] = 0;
    m_sat[k]  = 1'b0;
    m_oerr[k] = 1'b0;
    m_have[k] = 1'b0;
    m_exp[k]  = '0;
  endtask

  task automatic model_step(input int k);
    longint add[5];
    longint top;
    bit     reached;
    top = (longint'(1) << cw_of(k)) - 1;
    if (clr) begin
      model_clear(k);
      m_mode[k] = M_IDLE;
    end else if (arm) begin
      model_clear(k);
      m_mode[k] = M_RUN;
    end else if (m_mode[k] == M_RUN) begin
      reached = 1'b1;
      for (int c = 0; c < 5; c++) begin
        if (m_cnt[k][c] < thr_of(k, c)) reached = 1'b0;
        add[c] = 0;
      end
      for (int ch = 0; ch < nret_of(k); ch++) begin
        if (valid[ch]) begin
          if (trap[ch]) add[4]++;
          else begin
            if (rmask[ch*4 +: 4] != 0) add[0]++;
            if (wmask[ch*4 +: 4] != 0) add[1]++;
            if (insn[ch*32 +: 2] == 2'b11) add[2]++;
            else add[3]++;
          end
        end
      end
      for (int c = 0; c < 5; c++) begin
        if (m_cnt[k][c] + add[c] > top) begin
          m_cnt[k][c] = top;
          m_sat[k]    = 1'b1;
        end else begin
          m_cnt[k][c] = m_cnt[k][c] + add[c];
        end
      end
`ifdef SVX32_EVT_ORDER_CHECK_EN
      for (int ch = 1; ch < nret_of(k); ch++)
        if (valid[ch] && !valid[ch-1]) m_oerr[k] = 1'b1;
      for (int ch = 0; ch < nret_of(k); ch++) begin
        if (valid[ch]) begin
          if (m_have[k] && order[ch*64 +: 64] != m_exp[k]) m_oerr[k] = 1'b1;
          m_have[k] = 1'b1;
          m_exp[k]  = order[ch*64 +: 64] + 64'd1;
        end
      end
`endif
      if (reached) m_mode[k] = M_DONE;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        model_clear(k);
        m_mode[k] = M_IDLE;
      end
    end else begin
      for (int k = 0; k < NI; k++) model_step(k);
    end
  end

  // ---------------- DUT output access ----------------
  function automatic logic [63:0] get_cnt(input int k, input int c);
    case (k)
      0:       return 64'(cnt0[c*16 +: 16]);
      1:       return 64'(cnt1[c*16 +: 16]);
      default: return 64'(cnt2[c*4 +: 4]);
    endcase
  endfunction

  function automatic logic [63:0] get_state(input int k);
    case (k)
      0:       return 64'(st0);
      1:       return 64'(st1);
      default: return 64'(st2);
    endcase
  endfunction

  function automatic logic [63:0] get_goal(input int k);
    case (k)
      0:       return 64'(goal0);
      1:       return 64'(goal1);
      default: return 64'(goal2);
    endcase
  endfunction

  function automatic logic [63:0] get_sat(input int k);
    case (k)
      0:       return 64'(sat0);
      1:       return 64'(sat1);
      default: return 64'(sat2);
    endcase
  endfunction

  function automatic logic [63:0] get_oerr(input int k);
    case (k)
      0:       return 64'(oerr0);
      1:       return 64'(oerr1);
      default: return 64'(oerr2);
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d actual=%0d required=%0d t=%0t", name, k, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      check("state", k, get_state(k), 64'(m_mode[k]));
      check("goal_met", k, get_goal(k), 64'(m_mode[k] == M_DONE));
      check("sat", k, get_sat(k), 64'(m_sat[k]));
      check("order_err", k, get_oerr(k), 64'(m_oerr[k]));
      for (int c = 0; c < 5; c++) check(cls_name[c], k, get_cnt(k, c), 64'(m_cnt[k][c]));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) compare_all();
  end

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    valid = '0; trap = '0; insn = '0; rmask = '0; wmask = '0; order = '0;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] i, input logic t,
                        input logic [3:0] rm, input logic [3:0] wm, input logic [63:0] o);
    valid[ch]          = 1'b1;
    trap[ch]           = t;
    insn[ch*32 +: 32]  = i;
    rmask[ch*4 +: 4]   = rm;
    wmask[ch*4 +: 4]   = wm;
    order[ch*64 +: 64] = o;
  endtask

  // One retirement on channel 0 for one cycle.
  task automatic retire0(input logic [31:0] i, input logic t, input logic [3:0] rm,
                         input logic [3:0] wm);
    idle_bus();
    set_ch(0, i, t, rm, wm, 64'd0);
    @(negedge clk);
    idle_bus();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] prog [10];
    logic        prog_trap [10];
    prog = '{I_LW, I_SW, I_ADD, I_CADDI, I_LW, I_SW, I_ADD, I_CADDI, I_ECALL, I_ECALL};
    prog_trap = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    // reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 0, get_state(0), 64'd0);
    check("rst_cnt", 1, 64'(cnt1 != 0), 64'd0);
    check("rst_goal", 2, get_goal(2), 64'd0);
    check("rst_sat", 2, get_sat(2), 64'd0);
    check("rst_oerr", 1, get_oerr(1), 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // scenario 1: thresholds all 2, single-channel program
    thr16 = {5{16'd2}};
    thr4  = {5{4'd2}};
    pulse_arm();
    check("t1_armed_state", 0, get_state(0), 64'd1);
    for (int n = 0; n < 10; n++) begin
      retire0(prog[n], prog_trap[n], (prog[n] == I_LW) ? 4'hF : 4'h0,
              (prog[n] == I_SW) ? 4'hF : 4'h0);
    end
    check("t1_goal_before", 0, get_goal(0), 64'd0);
    @(negedge clk);
    check("t1_goal", 0, get_goal(0), 64'd1);
    check("t1_rd", 0, get_cnt(0, 0), 64'd2);
    check("t1_wr", 0, get_cnt(0, 1), 64'd2);
    check("t1_long", 0, get_cnt(0, 2), 64'd6);
    check("t1_compr", 0, get_cnt(0, 3), 64'd2);
    check("t1_trap", 0, get_cnt(0, 4), 64'd2);
    for (int n = 0; n < 3; n++) retire0(I_ADD, 1'b0, 4'h0, 4'h0);
    check("t1_frozen_long", 0, get_cnt(0, 2), 64'd6);
    check("t1_frozen_state", 0, get_state(0), 64'd2);

    // scenario 2: two channels of LW per cycle
    thr16 = {5{16'd100}};
    thr4  = {5{4'd15}};
    pulse_arm();
    for (int n = 0; n < 3; n++) begin
      idle_bus();
      set_ch(0, I_LW, 1'b0, 4'hF, 4'h0, 64'd0);
      set_ch(1, I_LW, 1'b0, 4'hF, 4'h0, 64'd0);
      @(negedge clk);
      if (n == 0) check("t2_rd_step", 1, get_cnt(1, 0), 64'd2);
    end
    idle_bus();
    check("t2_rd", 1, get_cnt(1, 0), 64'd6);
    check("t2_long", 1, get_cnt(1, 2), 64'd6);
    check("t2_rd_nret1", 0, get_cnt(0, 0), 64'd3);

    // scenario 3: 4-bit counters saturate on a stream of 20 ADDs
    thr4 = {4'd0, 4'd0, 4'd15, 4'd0, 4'd0};
    pulse_arm();
    for (int n = 0; n < 20; n++) begin
      retire0(I_ADD, 1'b0, 4'h0, 4'h0);
      if (n == 14) begin
        check("t3_long15", 2, get_cnt(2, 2), 64'd15);
        check("t3_sat_not_yet", 2, get_sat(2), 64'd0);
      end
    end
    check("t3_long", 2, get_cnt(2, 2), 64'd15);
    check("t3_sat", 2, get_sat(2), 64'd1);
    check("t3_state", 2, get_state(2), 64'd2);

    // scenario 4: arm and clr together, with a retirement on that edge
    pulse_arm();
    for (int n = 0; n < 5; n++) retire0(I_LW, 1'b0, 4'hF, 4'h0);
    check("t4_rd5", 0, get_cnt(0, 0), 64'd5);
    arm = 1'b1;
    clr = 1'b1;
    set_ch(0, I_LW, 1'b0, 4'hF, 4'h0, 64'd0);
    @(negedge clk);
    arm = 1'b0;
    clr = 1'b0;
    idle_bus();
    check("t4_state", 0, get_state(0), 64'd0);
    check("t4_cnt", 0, 64'(cnt0 != 0), 64'd0);
    check("t4_sat", 0, get_sat(0), 64'd0);
    retire0(I_LW, 1'b0, 4'hF, 4'h0);
    check("t4_idle_hold", 0, get_cnt(0, 0), 64'd0);

    // scenario 5: all thresholds zero
    thr16 = '0;
    thr4  = '0;
    pulse_arm();
    check("t5_run", 0, get_state(0), 64'd1);
    @(negedge clk);
    check("t5_done", 0, get_state(0), 64'd2);
    check("t5_goal", 1, get_goal(1), 64'd1);

    // scenario 6: order gap, then non-contiguous valid
    thr16 = {5{16'd100}};
    thr4  = {5{4'd15}};
    pulse_arm();
    idle_bus();
    set_ch(0, I_ADD, 1'b0, 4'h0, 4'h0, 64'd10);
    set_ch(1, I_ADD, 1'b0, 4'h0, 4'h0, 64'd11);
    @(negedge clk);
    check("t6_oerr_clean", 1, get_oerr(1), 64'd0);
    set_ch(0, I_ADD, 1'b0, 4'h0, 4'h0, 64'd13);
    set_ch(1, I_ADD, 1'b0, 4'h0, 4'h0, 64'd14);
    @(negedge clk);
    idle_bus();
    check("t6_oerr_gap", 1, get_oerr(1), 64'(EXP_OERR));
    pulse_arm();
    check("t6_oerr_cleared", 1, get_oerr(1), 64'd0);
    set_ch(1, I_ADD, 1'b0, 4'h0, 4'h0, 64'd20);
    @(negedge clk);
    idle_bus();
    check("t6_oerr_contig", 1, get_oerr(1), 64'(EXP_OERR));

    // scenario 7: asynchronous reset in the middle of a run
    pulse_arm();
    for (int n = 0; n < 3; n++) retire0(I_ADD, 1'b0, 4'h0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_state", 0, get_state(0), 64'd0);
    check("t7_rst_cnt", 0, 64'(cnt0 != 0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    retire0(I_ADD, 1'b0, 4'h0, 4'h0);
    check("t7_after_rst", 0, get_cnt(0, 2), 64'd0);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
